mem_master: RTL and testbench

MEM_MASTER -- requirements
Module: mem_master

---
 rtl/mem_master_pkg.sv | 24 ++
 rtl/mem_master.sv | 163 ++++++++++++++++
 tb/tb_mem_master.sv | 309 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_master_pkg.sv
// Shared encodings for mem_master: access sizes, FSM states and the beat-count helper.
package mem_master_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic [1:0] {
        StIdle,
        StAccess,
        StGap,
        StResp
    } state_e;

    // Size 2'b11 falls into the word case.
    function automatic logic [2:0] beat_count(input logic [1:0] size);
        case (size)
            SZ_BYTE: return 3'd1;
            SZ_HALF: return 3'd2;
            default: return 3'd4;
        endcase
    endfunction

endpackage

// File: rtl/mem_master.sv
// Byte-serial memory master: splits a CPU byte/half/word access into 8-bit memory beats.
// Define MEM_MASTER_TIMEOUT_EN to add a per-beat wait timeout that ends the access with resp_err.
module mem_master
    import mem_master_pkg::*;
#(
    parameter int unsigned ADDR_W  = 8,
    parameter int unsigned TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [1:0]        req_size,
    input  logic              req_signed,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    output logic [31:0]       resp_rdata,
    output logic              resp_err,
    output logic [ADDR_W-1:0] mem_address,
    output logic [7:0]        mem_wdata,
    input  logic [7:0]        mem_rdata,
    output logic              mem_read,
    output logic              mem_write,
    input  logic              mem_ready
);

    state_e              state_q, state_d;
    logic                write_q;
    logic [1:0]          size_q;
    logic                signed_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [31:0]         wdata_q;
    logic [1:0]          beat_q;
    logic [31:0]         rbuf_q;
    logic [31:0]         load_val;
    logic                accept;
    logic                beat_done;
    logic                last_beat;
    logic                timed_out;

    assign accept    = req_valid && req_ready;
    assign beat_done = (state_q == StAccess) && mem_ready;
    assign last_beat = ({1'b0, beat_q} == (beat_count(size_q) - 3'd1));

`ifdef MEM_MASTER_TIMEOUT_EN
    localparam int unsigned CntW = $clog2(TIMEOUT + 1);

    logic [CntW-1:0] tcnt_q;
    logic            err_q;

    // Counts waited ACCESS cycles of the current beat; cleared whenever a beat ends.
    assign timed_out = (state_q == StAccess) && !mem_ready && (tcnt_q == CntW'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            tcnt_q <= '0;
            err_q  <= 1'b0;
        end else begin
            if ((state_q == StAccess) && !mem_ready) begin
                tcnt_q <= tcnt_q + CntW'(1);
            end else begin
                tcnt_q <= '0;
            end
            if (accept) begin
                err_q <= 1'b0;
            end else if (timed_out) begin
                err_q <= 1'b1;
            end
        end
    end

    assign resp_err = (state_q == StResp) && err_q;
`else
    logic unused_timeout;
    assign unused_timeout = ^TIMEOUT;
    assign timed_out      = 1'b0;
    assign resp_err       = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        req_ready   = 1'b0;
        resp_valid  = 1'b0;
        mem_read    = 1'b0;
        mem_write   = 1'b0;
        mem_address = '0;
        mem_wdata   = 8'h00;
        unique case (state_q)
            StIdle: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    state_d = StAccess;
                end
            end
            StAccess: begin
                mem_read    = !write_q;
                mem_write   = write_q;
                mem_address = addr_q + ADDR_W'(beat_q);
                mem_wdata   = wdata_q[{beat_q, 3'b000} +: 8];
                if (mem_ready) begin
                    state_d = last_beat ? StResp : StGap;
                end else if (timed_out) begin
                    state_d = StResp;
                end
            end
            StGap: begin
                state_d = StAccess;
            end
            StResp: begin
                resp_valid = 1'b1;
                state_d    = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_comb begin
        case (size_q)
            SZ_BYTE: load_val = {{24{signed_q & rbuf_q[7]}}, rbuf_q[7:0]};
            SZ_HALF: load_val = {{16{signed_q & rbuf_q[15]}}, rbuf_q[15:0]};
            default: load_val = rbuf_q;
        endcase
    end

    // Stores and timed-out accesses report zero data.
    assign resp_rdata = ((state_q == StResp) && !write_q && !resp_err) ? load_val : 32'h0;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= StIdle;
            write_q  <= 1'b0;
            size_q   <= SZ_BYTE;
            signed_q <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= 32'h0;
            beat_q   <= 2'd0;
            rbuf_q   <= 32'h0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                write_q  <= req_write;
                size_q   <= req_size;
                signed_q <= req_signed;
                addr_q   <= req_addr;
                wdata_q  <= req_wdata;
                beat_q   <= 2'd0;
                rbuf_q   <= 32'h0;
            end else if (beat_done) begin
                if (!write_q) begin
                    rbuf_q[{beat_q, 3'b000} +: 8] <= mem_rdata;
                end
                if (!last_beat) begin
                    beat_q <= beat_q + 2'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_master.sv
// Self-checking bench for mem_master: directed spec scenarios plus random traffic
// against a byte-array reference model and a cycle-level protocol monitor.
module tb_mem_master;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_write = 1'b0;
    logic [1:0]  req_size = 2'b00;
    logic        req_signed = 1'b0;
    logic [7:0]  req_addr = 8'h00;
    logic [31:0] req_wdata = 32'h0;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [7:0]  mem_address;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata = 8'h00;
    logic        mem_read;
    logic        mem_write;
    logic        mem_ready = 1'b0;

    mem_master #(
        .ADDR_W (8),
        .TIMEOUT(15)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_write  (req_write),
        .req_size   (req_size),
        .req_signed (req_signed),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .mem_address(mem_address),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .mem_ready  (mem_ready)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    logic [7:0] mem     [0:255];
    logic [7:0] ref_mem [0:255];

    // Memory responder and protocol monitor state.
    bit         rand_delay = 1'b0;
    bit         noise      = 1'b0;
    bit         stall      = 1'b0;
    int         fixed_delay = 2;
    int         delay_cur   = 2;
    int         wait_cnt    = 0;
    bit         strobe, prev_strobe = 1'b0, prev_wr = 1'b0, prev_reset = 1'b1, beat_start;
    bit         in_txn = 1'b0;
    logic [7:0] prev_addr = 8'h00, prev_wdata = 8'h00;
    int         gap_cnt = 0;
    int         viol = 0;
    int         resp_cnt = 0;
    int         beat_starts = 0;
    int         strobe_cycles = 0;
    int         wait_log[$];
    logic [7:0] addr_log[$];

    always @(negedge clk) begin
        strobe = mem_read || mem_write;
        if (mem_read && mem_write) viol++;
        if (prev_reset) in_txn = 1'b0;
        // mem_ready here is the value the DUT sampled at the edge just past.
        if (prev_strobe && !mem_ready && !prev_reset && !stall) begin
            if (!strobe || mem_address !== prev_addr || mem_wdata !== prev_wdata ||
                mem_write !== prev_wr) viol++;
        end
        beat_start = strobe && (!prev_strobe || mem_ready);
        if (beat_start) begin
            if (in_txn && gap_cnt != 1) viol++;
            beat_starts++;
            addr_log.push_back(mem_address);
        end
        if (strobe) begin
            in_txn = 1'b1;
            gap_cnt = 0;
            strobe_cycles++;
        end else begin
            gap_cnt++;
        end
        if (resp_valid) begin
            in_txn = 1'b0;
            resp_cnt++;
        end
        prev_strobe = strobe;
        prev_wr     = mem_write;
        prev_addr   = mem_address;
        prev_wdata  = mem_wdata;
        prev_reset  = reset;

        if (strobe && !stall && wait_cnt >= delay_cur) begin
            mem_ready = 1'b1;
            mem_rdata = mem[mem_address];
            if (mem_write) mem[mem_address] = mem_wdata;
            wait_log.push_back(wait_cnt);
            wait_cnt  = 0;
            delay_cur = rand_delay ? int'($urandom_range(0, 3)) : fixed_delay;
        end else if (strobe) begin
            mem_ready = 1'b0;
            mem_rdata = 8'($urandom);
            wait_cnt++;
        end else begin
            mem_ready = noise ? 1'($urandom_range(0, 1)) : 1'b0;
            mem_rdata = 8'($urandom);
            wait_cnt  = 0;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    function automatic int nbytes(input logic [1:0] sz);
        return (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
    endfunction

    function automatic logic [31:0] ref_load(input logic [7:0] a, input logic [1:0] sz,
                                             input bit sg);
        logic [31:0] v = 32'h0;
        int n = nbytes(sz);
        for (int i = 0; i < n; i++) v = v | (32'(ref_mem[8'(a + 8'(i))]) << (8 * i));
        if (sg && n < 4 && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8 * n));
        return v;
    endfunction

    function automatic int ref_latency(input int n);
        int s = 0;
        foreach (wait_log[i]) s += wait_log[i] + 1;
        return s + (n - 1) + 1;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issues one request from an idle master and waits (bounded) for its response.
    task automatic run_txn(input bit wr, input logic [1:0] sz, input bit sg,
                           input logic [7:0] a, input logic [31:0] wd,
                           output logic [31:0] rd, output logic er, output int lat);
        wait_log.delete();
        addr_log.delete();
        req_valid  = 1'b1;
        req_write  = wr;
        req_size   = sz;
        req_signed = sg;
        req_addr   = a;
        req_wdata  = wd;
        chk("req_ready_idle", 32'(req_ready), 32'd1);
        tick();
        req_valid = 1'b0;
        lat = 1;
        while (!resp_valid && lat < 400) begin
            tick();
            lat++;
        end
        chk("resp_seen", 32'(resp_valid), 32'd1);
        rd = resp_rdata;
        er = resp_err;
        tick();
        chk("resp_one_cycle", 32'(resp_valid), 32'd0);
    endtask

    logic [31:0] rd, exp_rd;
    logic        er;
    int          lat, diffs, base, cyc;
    bit          wr, sg;
    logic [1:0]  sz;
    logic [7:0]  a;
    logic [31:0] wd;

    initial begin
        for (int i = 0; i < 256; i++) begin
            mem[i]     = 8'($urandom);
            ref_mem[i] = mem[i];
        end
        reset = 1'b1;
        repeat (3) tick();
        chk("rst_req_ready", 32'(req_ready), 32'd1);
        chk("rst_outputs", {resp_valid, resp_err, mem_read, mem_write, mem_address, mem_wdata},
            32'h0);
        chk("rst_rdata", resp_rdata, 32'h0);
        reset = 1'b0;
        tick();

        // Word store, memory delay 2.
        run_txn(1'b1, 2'b10, 1'b0, 8'h10, 32'hA1B2C3D4, rd, er, lat);
        for (int i = 0; i < 4; i++) ref_mem[8'h10 + i] = 8'(32'hA1B2C3D4 >> (8 * i));
        chk("st_word_mem", {mem[8'h13], mem[8'h12], mem[8'h11], mem[8'h10]}, 32'hA1B2C3D4);
        chk("st_word_latency", 32'(lat), 32'd16);
        chk("st_word_err", 32'(er), 32'd0);
        chk("st_word_rdata", rd, 32'h0);

        // Signed and unsigned byte loads of 0x80.
        mem[8'h05] = 8'h80;
        ref_mem[8'h05] = 8'h80;
        run_txn(1'b0, 2'b00, 1'b1, 8'h05, 32'h0, rd, er, lat);
        chk("ld_byte_signed", rd, 32'hFFFFFF80);
        run_txn(1'b0, 2'b00, 1'b0, 8'h05, 32'h0, rd, er, lat);
        chk("ld_byte_unsigned", rd, 32'h00000080);

        // Half load wrapping from 0xFF to 0x00.
        mem[8'hFF] = 8'h34;
        ref_mem[8'hFF] = 8'h34;
        mem[8'h00] = 8'h12;
        ref_mem[8'h00] = 8'h12;
        run_txn(1'b0, 2'b01, 1'b0, 8'hFF, 32'h0, rd, er, lat);
        chk("ld_half_wrap", rd, 32'h00001234);
        chk("ld_half_nbeats", 32'(addr_log.size()), 32'd2);
        if (addr_log.size() == 2) chk("ld_half_addrs", {16'h0, addr_log[0], addr_log[1]},
                                      32'h0000FF00);

        // Reset in the middle of beat 2 of a word store.
        for (int i = 0; i < 4; i++) begin
            mem[8'h40 + i]     = 8'h00;
            ref_mem[8'h40 + i] = 8'h00;
        end
        base = beat_starts;
        req_valid  = 1'b1;
        req_write  = 1'b1;
        req_size   = 2'b10;
        req_signed = 1'b0;
        req_addr   = 8'h40;
        req_wdata  = 32'h11223344;
        tick();
        req_valid = 1'b0;
        cyc = 0;
        while (beat_starts < base + 3 && cyc < 100) begin
            tick();
            cyc++;
        end
        chk("abort_reached_beat2", 32'(beat_starts - base), 32'd3);
        base = resp_cnt;
        reset = 1'b1;
        tick();
        chk("abort_strobes", {30'h0, mem_read, mem_write}, 32'h0);
        chk("abort_req_ready", 32'(req_ready), 32'd1);
        reset = 1'b0;
        repeat (30) tick();
        chk("abort_no_resp", 32'(resp_cnt - base), 32'd0);
        ref_mem[8'h40] = 8'h44;
        ref_mem[8'h41] = 8'h33;
        chk("abort_mem", {mem[8'h43], mem[8'h42], mem[8'h41], mem[8'h40]}, 32'h00003344);

`ifdef MEM_MASTER_TIMEOUT_EN
        stall = 1'b1;
        base = strobe_cycles;
        run_txn(1'b0, 2'b10, 1'b0, 8'h20, 32'h0, rd, er, lat);
        chk("tmo_strobe_cycles", 32'(strobe_cycles - base), 32'd15);
        chk("tmo_err", 32'(er), 32'd1);
        chk("tmo_rdata", rd, 32'h0);
        chk("tmo_latency", 32'(lat), 32'd16);
        stall = 1'b0;
        tick();
`endif

        // Random traffic with random beat waits and stray mem_ready outside accesses.
        rand_delay = 1'b1;
        noise      = 1'b1;
        for (int t = 0; t < 40; t++) begin
            wr = 1'($urandom_range(0, 1));
            sz = 2'($urandom_range(0, 3));
            sg = 1'($urandom_range(0, 1));
            a  = 8'($urandom);
            if ($urandom_range(0, 3) == 0) a = 8'(8'hFC + 8'($urandom_range(0, 3)));
            wd = $urandom;
            exp_rd = wr ? 32'h0 : ref_load(a, sz, sg);
            if (wr) begin
                for (int i = 0; i < nbytes(sz); i++) ref_mem[8'(a + 8'(i))] = 8'(wd >> (8 * i));
            end
            run_txn(wr, sz, sg, a, wd, rd, er, lat);
            chk("rand_rdata", rd, exp_rd);
            chk("rand_err", 32'(er), 32'd0);
            chk("rand_latency", 32'(lat), 32'(ref_latency(nbytes(sz))));
        end
        noise = 1'b0;
        repeat (3) tick();

        diffs = 0;
        for (int i = 0; i < 256; i++) if (mem[i] !== ref_mem[i]) diffs++;
        chk("final_mem_bytes_differing", 32'(diffs), 32'd0);
        chk("protocol_violations", 32'(viol), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
